rf_wb_arbiter: RTL
==================

RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 The block SHALL have parameter REG_W, default 5, register address width.
REQ-002 The block SHALL have parameter REG_S, default 32, number of registers (2..2^REG_W).
REQ-003 The block SHALL have parameter DATA_W, default 32, register data width.
REQ-004 The block SHALL run on one clock; reset is asynchronous and active-low.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 a_valid / a_ready / a_addr / a_data  in / out / in / in  1 / 1 / REG_W / DATA_W  writeback source A (ALU).
REQ-008 b_valid / b_ready / b_addr / b_data  in / out / in / in  1 / 1 / REG_W / DATA_W  writeback source B (load unit).
REQ-009 rf_we / rf_a3 / rf_wd  out / out / out  1 / REG_W / DATA_W  register file write port, registered.
REQ-010 busy  out  1  high while the init sweep runs.

Function
REQ-011 The block SHALL have two states: INIT (clearing sweep) and RUN (arbitration).
REQ-012 A source SHALL transfer on a cycle where its valid and ready are both high at the rising clk edge.
REQ-013 In RUN: a_ready = !b_valid || last_grant==B; b_ready = !a_valid || last_grant==A; in INIT both readys SHALL be 0.
REQ-014 When both sources are valid in RUN, the grant SHALL go to the source not recorded in last_grant.
REQ-015 last_grant SHALL update to the granted source on every transfer, contested or not.
REQ-016 A transfer at edge N SHALL drive rf_we=1, rf_a3=addr, rf_wd=data during cycle N+1 (latency 1).
REQ-017 A transfer with addr==0 SHALL complete the handshake but SHALL leave rf_we=0 on the following cycle.
REQ-018 With no transfer, rf_we SHALL be 0 on the next cycle; rf_a3 and rf_wd SHALL hold their previous values.
REQ-019 In INIT, an internal counter SHALL start at 1 and, each cycle, drive rf_we=1, rf_a3=counter, rf_wd=0, then increment.
REQ-020 After the cycle writing REG_S-1, the block SHALL enter RUN; busy SHALL equal (state==INIT).
REQ-021 Register 0 SHALL never be written.
REQ-022 The counter SHALL never exceed REG_S-1 and SHALL not wrap.
REQ-023 No input accepted in INIT SHALL be buffered or lost; senders hold valid until ready.

Reset
REQ-024 While rst_n=0, outputs SHALL be rf_we=0, rf_a3=0, rf_wd=0, a_ready=0, b_ready=0.
REQ-025 Reset SHALL set last_grant=B, so A wins the first contest, and counter=1.
REQ-026 Reset asserted mid-sweep or mid-transfer SHALL abort immediately; after release the sweep SHALL restart at register 1.

Configuration
REQ-027 The macro RF_INIT_CLEAR_EN SHALL control the init sweep.
REQ-028 With RF_INIT_CLEAR_EN defined, reset SHALL enter INIT with busy=1.
REQ-029 With RF_INIT_CLEAR_EN undefined, reset SHALL enter RUN directly, busy SHALL be constant 0, and the counter logic SHALL be absent.

Verification (REG_W=5, REG_S=32, DATA_W=32)
REQ-030 Macro defined, release rst_n -> 31 cycles of rf_we=1, rf_a3=1..31, rf_wd=0, busy=1; busy=0 and a_ready=1 on the next cycle.
REQ-031 RUN, a_valid=1, a_addr=3, a_data=0xDEADBEEF for one cycle -> next cycle rf_we=1, rf_a3=3, rf_wd=0xDEADBEEF, then rf_we=0.
REQ-032 RUN, a_valid=b_valid=1 held, a_addr=5, b_addr=6 -> rf_a3 sequence 5,6,5,6 with one write per cycle.
REQ-033 RUN, b_valid=1, b_addr=0, b_data=0x1234 -> b_ready=1 and rf_we=0 on the following cycle.
REQ-034 Macro defined, rst_n pulsed low when rf_a3=10 during sweep -> outputs 0 at once; after release the sweep restarts at rf_a3=1.
REQ-035 Macro undefined, release rst_n with a_valid=1 -> a_ready=1 in the first cycle and busy stays 0.

Source files
------------

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter
//   Arbitrates two writeback sources (A = ALU, B = load unit) onto a single
//   registered register-file write port. Contested cycles alternate between
//   the sources; a write to register 0 completes its handshake but is dropped.
//   Optionally sweeps registers 1..REG_S-1 to zero after reset.
//
// Configuration macro:
//   RF_INIT_CLEAR_EN  defined   -> reset enters INIT and clears the register file
//                     undefined -> reset enters RUN directly, busy tied to 0
//
// Ports:
//   clk, rst_n                        clock, asynchronous active-low reset
//   a_valid/a_ready/a_addr/a_data     writeback source A
//   b_valid/b_ready/b_addr/b_data     writeback source B
//   rf_we/rf_a3/rf_wd                 registered register-file write port
//   busy                              high while the clearing sweep runs
//
// States:
//   INIT | clearing sweep, both sources held off
//   RUN  | arbitration between A and B

module rf_wb_arbiter #(
    parameter int REG_W  = 5,
    parameter int REG_S  = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              a_valid,
    output logic              a_ready,
    input  logic [REG_W-1:0]  a_addr,
    input  logic [DATA_W-1:0] a_data,

    input  logic              b_valid,
    output logic              b_ready,
    input  logic [REG_W-1:0]  b_addr,
    input  logic [DATA_W-1:0] b_data,

    output logic              rf_we,
    output logic [REG_W-1:0]  rf_a3,
    output logic [DATA_W-1:0] rf_wd,

    output logic              busy
);

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [REG_W-1:0] LAST_REG = REG_W'(REG_S - 1);

    state_t state;
    state_t state_next;

    // 1: source B received the most recent grant, 0: source A did
    logic last_grant_b;

    logic a_xfer;
    logic b_xfer;

`ifdef RF_INIT_CLEAR_EN
    logic [REG_W-1:0] counter;
    logic             sweep_done;

    // The sweep is finished once the write of the last register is on the
    // port; leaving INIT one cycle later keeps busy high for that write.
    assign sweep_done = rf_we && (rf_a3 == LAST_REG);
    assign busy       = (state == INIT);
`else
    assign busy = 1'b0;
`endif

    assign a_xfer = a_valid && a_ready;
    assign b_xfer = b_valid && b_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
`ifdef RF_INIT_CLEAR_EN
            state <= INIT;
`else
            state <= RUN;
`endif
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        a_ready    = 1'b0;
        b_ready    = 1'b0;
        case (state)
            INIT: begin
`ifdef RF_INIT_CLEAR_EN
                if (sweep_done) begin
                    state_next = RUN;
                end
`else
                state_next = RUN;
`endif
            end
            RUN: begin
                // rst_n gates the readys so they read 0 while reset is held
                // even in the build where reset lands directly in RUN.
                if (rst_n) begin
                    a_ready = !b_valid || last_grant_b;
                    b_ready = !a_valid || !last_grant_b;
                end
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we        <= 1'b0;
            rf_a3        <= '0;
            rf_wd        <= '0;
            last_grant_b <= 1'b1;
`ifdef RF_INIT_CLEAR_EN
            counter      <= REG_W'(1);
`endif
        end else begin
`ifdef RF_INIT_CLEAR_EN
            if (state == INIT) begin
                if (sweep_done) begin
                    rf_we <= 1'b0;
                end else begin
                    rf_we <= 1'b1;
                    rf_a3 <= counter;
                    rf_wd <= '0;
                    // Saturate at the last register instead of wrapping
                    if (counter != LAST_REG) begin
                        counter <= counter + REG_W'(1);
                    end
                end
            end else
`endif
            if (a_xfer) begin
                last_grant_b <= 1'b0;
                if (a_addr != '0) begin
                    rf_we <= 1'b1;
                    rf_a3 <= a_addr;
                    rf_wd <= a_data;
                end else begin
                    rf_we <= 1'b0;
                end
            end else if (b_xfer) begin
                last_grant_b <= 1'b1;
                if (b_addr != '0) begin
                    rf_we <= 1'b1;
                    rf_a3 <= b_addr;
                    rf_wd <= b_data;
                end else begin
                    rf_we <= 1'b0;
                end
            end else begin
                rf_we <= 1'b0;
            end
        end
    end

endmodule
